cdb_rr_arbiter: RTL
===================

Name: cdb_rr_arbiter

Overview:
- Parametrised successor to the fixed-priority common data bus stage.
- Accepts results from NUM_SRC functional-unit sources through per-source FIFOs of depth QDEPTH, using a valid/ready handshake.
- Broadcasts up to LANES results per cycle to ROB, RS and PRF, with round-robin priority so no source starves.
- Supports a per-entry writeback enable (branch-only results reach the ROB but not the CDB) and a pipeline flush.

Parameters:
- NUM_SRC, 8: number of producer sources (ALU + MULT + LOAD slots, flattened).
- LANES, `N: number of broadcast lanes per cycle; must satisfy 1 <= LANES <= NUM_SRC.
- QDEPTH, 2: entries per source FIFO; power of two, >= 1.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all queued entries.
- in_valid  input  NUM_SRC  per-source request valid.
- in_packet  input  NUM_SRC x $bits(CDB_REQ_PACKET)  per-source result.
- in_ready  output  NUM_SRC  per-source space available.
- fu_rob_packet  output  LANES x $bits(FU_ROB_PACKET)  completion to ROB; executed=1 marks a valid lane.
- cdb_output  output  LANES x $bits(CDB_PACKET)  tag/value broadcast to RS/PRF.
- grant_debug  output  NUM_SRC  one-hot-per-lane OR of sources dequeued this cycle.

Behaviour:
- Reset (async, active-high):
  - all FIFOs empty; rr_ptr=0; in_ready all 1.
  - fu_rob_packet and cdb_output all zero; grant_debug 0.
- Handshake:
  - in_ready[s] = (count[s] < QDEPTH), registered-state only.
  - in_ready has no combinational path from grant; a full FIFO refuses input even in a cycle where it drains.
  - Enqueue occurs on the clock edge when in_valid[s] & in_ready[s].
  - in_valid with in_ready=0 means the source must hold the packet (FU stalls).
- Latency:
  - An entry enqueued at edge t may appear on an output lane during cycle t+1 at earliest; there is no bypass.
  - Outputs are combinational from FIFO heads and registered rr_ptr.
- Selection:
  - Candidates are sources with non-empty FIFOs.
  - Scan from index rr_ptr upward, wrapping modulo NUM_SRC; the first LANES candidates win.
  - Lane k gets the k-th winner in scan order; winners pop on the edge.
  - Unused lanes drive all-zero packets.
  - When >= 1 grant: rr_ptr_next = (last winner index + 1) mod NUM_SRC.
  - When no grant: rr_ptr is unchanged.
- Packet mapping per lane:
  - fu_rob_packet = {robn, 1, take_branch, target_addr}.
  - cdb_output = wb_en ? {dest_prn, result} : {0, 0}.
  - Entries with wb_en=0 still consume a lane.
- Simultaneous enqueue and dequeue on one FIFO: count unchanged, order preserved. Pointers wrap modulo QDEPTH.
- Flush (registered):
  - At the edge: all counts go to 0; same-cycle enqueues are dropped; same-cycle grants do not update rr_ptr.
  - During the flush cycle, all outputs are forced to zero.
  - Flush held for multiple cycles keeps the block empty.
- Reset asserted mid-operation: state clears immediately (asynchronously); outputs go to zero without waiting for a clock edge.
- Per-source ordering is strictly FIFO. There is no cross-source ordering guarantee.

Optional Feature:
- Macro: CDB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, NUM_SRC x 16 bits.
  - Counter s increments each cycle in_valid[s] & ~in_ready[s], saturating at 16'hFFFF.
  - Counters clear on reset only; flush does not clear them.
- Undefined: the port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- sys_defs package:
  - CDB_REQ_PACKET {ROBN robn; PRN dest_prn; DATA result; logic take_branch; ADDR target_addr; logic wb_en}.
  - Reuse FU_ROB_PACKET and CDB_PACKET.
  - Add `CDB_QDEPTH and `CDB_NUM_SRC defaults.
- Sub-module cdb_src_queue: one FIFO per source, parameter QDEPTH.
  - Ports: clock, reset, flush, enq, enq_packet, deq, head, empty, full.
- The top module holds the rr scan, lane mapping and the optional counters.

Test Plan (NUM_SRC=4, LANES=2, QDEPTH=2):
- Reset then idle: in_ready=4'b1111, all lanes zero, grant_debug=0.
- Single request: source 2 valid with dest_prn=5, result=32'hABCD, wb_en=1 at edge 0 -> cycle 1 lane0 cdb_output={5, 32'hABCD}, lane1 zero; rr_ptr becomes 3.
- Fairness:
  - All 4 sources stream continuously from rr_ptr=0.
  - Grants must rotate {0,1}, {2,3}, {0,1}, ...
  - Every source must be granted at least once every 2 cycles.
- Backpressure:
  - Source 1 pushes 3 back-to-back entries while lanes are saturated by sources 0, 2 and 3.
  - in_ready[1]=0 after 2 enqueues.
  - Entries drain in order A, B, C.
  - With CDB_STALL_CNT_EN, stall_cnt[1] counts the refused cycles exactly.
- Branch-only: wb_en=0, take_branch=1, target_addr=32'h100 -> fu_rob_packet={robn, 1, 1, 32'h100}, cdb_output={0, 0}.
- Flush:
  - Fill all FIFOs, then assert flush for 1 cycle alongside new in_valid.
  - Next cycle: all lanes zero, in_ready=4'b1111, no stale entries emerge; an asynchronous reset mid-stream behaves the same.

Source files
------------

// File: rtl/cdb_rr_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// cdb_rr_arbiter_pkg : packet types and build defaults for the round-robin CDB
// Rev 1.0
// =============================================================================
`ifndef CDB_NUM_SRC
`define CDB_NUM_SRC 8
`endif
`ifndef CDB_QDEPTH
`define CDB_QDEPTH 2
`endif
`ifndef N
`define N 2
`endif

package cdb_rr_arbiter_pkg;

  localparam int unsigned c_ROBN_W = 5;
  localparam int unsigned c_PRN_W  = 6;
  localparam int unsigned c_DATA_W = 32;
  localparam int unsigned c_ADDR_W = 32;

  typedef logic [c_ROBN_W-1:0] ROBN;
  typedef logic [c_PRN_W-1:0]  PRN;
  typedef logic [c_DATA_W-1:0] DATA;
  typedef logic [c_ADDR_W-1:0] ADDR;

  typedef struct packed {
    ROBN  robn;
    logic executed;
    logic take_branch;
    ADDR  target_addr;
  } FU_ROB_PACKET;

  typedef struct packed {
    PRN  tag;
    DATA value;
  } CDB_PACKET;

  typedef struct packed {
    ROBN  robn;
    PRN   dest_prn;
    DATA  result;
    logic take_branch;
    ADDR  target_addr;
    logic wb_en;
  } CDB_REQ_PACKET;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_src_queue.sv
`default_nettype none
// =============================================================================
// cdb_src_queue : per-source result FIFO with synchronous squash
// Rev 1.0
// =============================================================================
module cdb_src_queue
  import cdb_rr_arbiter_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          enq,
  input  CDB_REQ_PACKET enq_packet,
  input  logic          deq,
  output CDB_REQ_PACKET head,
  output logic          empty,
  output logic          full
);

  localparam int unsigned c_PW = idx_w(QDEPTH);
  localparam int unsigned c_CW = $clog2(QDEPTH + 1);

  CDB_REQ_PACKET   mem_q [QDEPTH];
  logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CW-1:0] count_q, count_d;
  logic            do_enq, do_deq;

  function automatic logic [c_PW-1:0] bump(input logic [c_PW-1:0] p);
    return (p == c_PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == c_CW'(QDEPTH));
  assign head   = mem_q[rd_ptr_q];
  assign do_enq = enq & ~full & ~flush;
  assign do_deq = deq & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = do_enq ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_deq ? bump(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_enq && !do_deq) count_d = count_q + 1'b1;
    if (do_deq && !do_enq) count_d = count_q - 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only visible through a non-empty head.
  always_ff @(posedge clock) begin
    if (do_enq) mem_q[wr_ptr_q] <= enq_packet;
  end

endmodule
`default_nettype wire

// File: rtl/cdb_rr_arbiter.sv
`default_nettype none
// =============================================================================
// cdb_rr_arbiter : multi-lane round-robin common data bus with source FIFOs
// Optional stall counters: define CDB_STALL_CNT_EN.     Rev 1.0
// =============================================================================
module cdb_rr_arbiter
  import cdb_rr_arbiter_pkg::*;
#(
  parameter int NUM_SRC = `CDB_NUM_SRC,
  parameter int LANES   = `N,
  parameter int QDEPTH  = `CDB_QDEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic          [NUM_SRC-1:0]  in_valid,
  input  CDB_REQ_PACKET [NUM_SRC-1:0]  in_packet,
  output logic          [NUM_SRC-1:0]  in_ready,
  output FU_ROB_PACKET  [LANES-1:0]    fu_rob_packet,
  output CDB_PACKET     [LANES-1:0]    cdb_output,
  output logic          [NUM_SRC-1:0]  grant_debug
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [NUM_SRC-1:0][15:0]     stall_cnt
`endif
);

  localparam int unsigned c_SW  = idx_w(NUM_SRC);
  localparam int unsigned c_SW1 = c_SW + 1;
  localparam int unsigned c_LW  = idx_w(LANES);
  localparam int unsigned c_LW1 = c_LW + 1;

  CDB_REQ_PACKET                head_w [NUM_SRC];
  logic [NUM_SRC-1:0]           empty_w, full_w, grant_w;
  logic [LANES-1:0]             lane_vld_w;
  logic [LANES-1:0][c_SW-1:0]   lane_src_w;
  logic [c_SW-1:0]              last_win_w;
  logic [c_SW-1:0]              rr_ptr_q, rr_ptr_d;

  assign in_ready = ~full_w;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    cdb_src_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .enq        (in_valid[s] & in_ready[s]),
      .enq_packet (in_packet[s]),
      .deq        (grant_w[s]),
      .head       (head_w[s]),
      .empty      (empty_w[s]),
      .full       (full_w[s])
    );
  end

  // Scan from rr_ptr with wrap; the k-th non-empty source takes lane k.
  always_comb begin
    logic [c_SW1-1:0] pos;
    logic [c_LW1-1:0] nwin;
    grant_w    = '0;
    lane_vld_w = '0;
    lane_src_w = '0;
    last_win_w = rr_ptr_q;
    nwin       = '0;
    pos        = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = {1'b0, rr_ptr_q} + c_SW1'(k);
      if (pos >= c_SW1'(NUM_SRC)) pos = pos - c_SW1'(NUM_SRC);
      if (!empty_w[pos[c_SW-1:0]] && (nwin < c_LW1'(LANES))) begin
        grant_w[pos[c_SW-1:0]]     = 1'b1;
        lane_vld_w[nwin[c_LW-1:0]] = 1'b1;
        lane_src_w[nwin[c_LW-1:0]] = pos[c_SW-1:0];
        last_win_w                 = pos[c_SW-1:0];
        nwin                       = nwin + 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!flush && (|grant_w))
      rr_ptr_d = (last_win_w == c_SW'(NUM_SRC - 1)) ? '0 : last_win_w + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  always_comb begin
    CDB_REQ_PACKET pkt;
    fu_rob_packet = '0;
    cdb_output    = '0;
    pkt           = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_vld_w[l] && !flush) begin
        pkt                          = head_w[lane_src_w[l]];
        fu_rob_packet[l].robn        = pkt.robn;
        fu_rob_packet[l].executed    = 1'b1;
        fu_rob_packet[l].take_branch = pkt.take_branch;
        fu_rob_packet[l].target_addr = pkt.target_addr;
        if (pkt.wb_en) begin
          cdb_output[l].tag   = pkt.dest_prn;
          cdb_output[l].value = pkt.result;
        end
      end
    end
  end

  assign grant_debug = flush ? '0 : grant_w;

`ifdef CDB_STALL_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (in_valid[s] && !in_ready[s] && (stall_cnt[s] != 16'hFFFF))
          stall_cnt[s] <= stall_cnt[s] + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
